ballot_collector: RTL and testbench
===================================

# ballot_collector

Sequential front end for the five-input voting stage. Accepts five single-bit votes one at a time over a valid/ready handshake, in order s2, s1, s0, t, p, and holds them as stable registered levels on the combinational voting block's inputs. Samples the returned decision `g` and keeps saturating pass/fail tallies. Handles abort and inactivity timeout so the voting block never sees a partial ballot as final.

## Interface
- `TIMEOUT`, default 1000: cycles without an accepted vote in COLLECT before the ballot is dropped; legal range ≥ 2.
- `CNT_W`, default 8: width of the pass/fail tallies.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: opens a ballot; honoured only in IDLE.
- `abort` in 1: drops the current ballot.
- `vote_valid` in 1: `vote_in` is presented.
- `vote_in` in 1: 1 = yes, 0 = no.
- `vote_ready` out 1: high only in COLLECT.
- `g` in 1: decision returned by the downstream voting block.
- `s2`, `s1`, `s0`, `t`, `p` out 1 each: registered votes to the voting block.
- `busy` out 1: state ≠ IDLE.
- `ballot_done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 1: last sampled `g`; held until the next `ballot_done`.
- `pass_count` out `CNT_W`: ballots with result 1.
- `fail_count` out `CNT_W`: ballots with result 0.
- `timeout_err` out 1: sticky; cleared by an honoured `start`.

## Operation
- States:
  - IDLE: `start` → COLLECT.
  - COLLECT: 5th accepted vote → EVAL; `abort` or timeout → IDLE.
  - EVAL: `abort` → IDLE, no sampling; otherwise → DONE.
  - DONE: → IDLE unconditionally.
- Vote acceptance:
  - Accepted when `vote_valid & vote_ready`.
  - A 3-bit index 0..4 selects the register written: 0→s2, 1→s1, 2→s0, 3→t, 4→p.
  - The index increments on each acceptance.
- An honoured `start` clears all five vote registers, the index and the timer, and clears `timeout_err`.
- `start` while busy is ignored.
- In EVAL the five registers are stable, so `g` has settled; `g` is sampled into `result` at the EVAL→DONE edge, and the matching tally increments on the same edge.
- Tallies saturate at 2^CNT_W−1 and never wrap. Only reset clears them.
- Abort:
  - Takes priority over `vote_valid` in the same cycle; that vote is not accepted.
  - Clears the vote registers; no tally change, no `ballot_done`, `result` unchanged.
- Timeout:
  - The timer counts COLLECT cycles since `start` or the last acceptance.
  - When it reaches `TIMEOUT` without an acceptance, the block goes to IDLE, sets `timeout_err`, clears the votes, and leaves the tallies unchanged.
  - An acceptance in the same cycle the timer reaches `TIMEOUT` wins: no timeout.
- Simultaneous `start` and `abort` in IDLE: `start` is honoured (abort has no meaning in IDLE).

## Timing
- Reset: state IDLE; all outputs 0, including vote registers, `result`, tallies and `timeout_err`.
- `start` sampled at edge N → `vote_ready` = 1 from cycle N+1.
- Maximum throughput is one vote per cycle; a ballot needs a minimum of 5 COLLECT cycles.
- 5th vote accepted at edge M → cycle M+1 is EVAL; `ballot_done` = 1 and `result`/tally updated in cycle M+2; `busy` = 0 from cycle M+3.
- Earliest next `start` is honoured at edge M+3.
- All outputs are registered. `vote_ready` and `busy` decode directly from state flops.
- Reset asserted mid-ballot: immediate return to reset values, asynchronously; no partial tally update.

## Structure
- Package `ballot_pkg`: state enum (IDLE, COLLECT, EVAL, DONE), `NUM_VOTES` = 5, vote-index constants `IDX_S2`..`IDX_P`.
- Sub-module `sat_counter` (parameter `W`, inputs `inc` and `rst_n`), instantiated twice for the pass and fail tallies.
- Test bench instantiates `ballot_collector` feeding the existing voting stage (majority of the s-majority, `t` and `p`), with `g` looped back.

## Test plan
- Reset, then `start`, votes 1,1,0,1,0 back-to-back → `ballot_done` 2 cycles after the 5th vote, `result` = 1, `pass_count` = 1, `fail_count` = 0.
- Votes 1,1,1,0,0 with gaps of 3 idle cycles → `result` = 0, `fail_count` = 1; s2/s1/s0/t/p stay 1,1,1,0,0 until the next `start`.
- 3 votes, then `abort` asserted together with `vote_valid` → vote not accepted, IDLE next cycle, vote outputs 0, tallies unchanged, no `ballot_done`.
- `TIMEOUT` = 4, `start`, 2 votes, then silence → `timeout_err` = 1, IDLE after 4 silent cycles; next `start` clears `timeout_err`.
- `CNT_W` = 2, five passing ballots → `pass_count` sticks at 3.
- `rst_n` pulsed low during EVAL → all outputs 0 immediately; `start` pulsed while busy → ignored, index unchanged.

Source files
------------

// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot collector.
// State encoding, vote count and the vote-index map.
package ballot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EVAL,
        DONE
    } state_t;

    localparam int NUM_VOTES = 5;

    localparam logic [2:0] IDX_S2 = 3'd0;
    localparam logic [2:0] IDX_S1 = 3'd1;
    localparam logic [2:0] IDX_S0 = 3'd2;
    localparam logic [2:0] IDX_T  = 3'd3;
    localparam logic [2:0] IDX_P  = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pass/fail tallies.
// Ports: clk, rst_n (async, active-low), inc, count[W-1:0].
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ballot_collector.sv
// Collects five serial votes for the voting block, samples its decision.
// Ports: start/abort control, vote_valid/vote_in/vote_ready handshake,
//   g from voting block, registered votes s2..p, busy, ballot_done,
//   result, pass_count/fail_count tallies, sticky timeout_err.
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             vote_valid,
    input  logic             vote_in,
    output logic             vote_ready,
    input  logic             g,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic             t,
    output logic             p,
    output logic             busy,
    output logic             ballot_done,
    output logic             result,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             timeout_err
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_n;
    logic [2:0]       idx;
    logic [TMR_W-1:0] timer;

    logic in_collect;
    logic in_eval;
    logic accept;
    logic tmo;
    logic sample;
    logic pass_inc;
    logic fail_inc;

    assign in_collect = (state == COLLECT);
    assign in_eval    = (state == EVAL);

    // abort outranks a vote presented in the same cycle
    assign accept = in_collect & vote_valid & ~abort;

    // an acceptance on the final silent cycle resets the timer instead
    assign tmo = in_collect & ~abort & ~vote_valid & (timer == TMR_LAST);

    assign sample   = in_eval & ~abort;
    assign pass_inc = sample & g;
    assign fail_inc = sample & ~g;

    assign vote_ready  = in_collect;
    assign busy        = (state != IDLE);
    assign ballot_done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = COLLECT;
            end
            COLLECT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (accept && (idx == IDX_P)) begin
                    state_n = EVAL;
                end else if (tmo) begin
                    state_n = IDLE;
                end
            end
            EVAL: begin
                state_n = abort ? IDLE : DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s2, s1, s0, t, p} <= '0;
            idx                <= '0;
            timer              <= '0;
            result             <= 1'b0;
            timeout_err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        {s2, s1, s0, t, p} <= '0;
                        idx                <= '0;
                        timer              <= '0;
                        timeout_err        <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        {s2, s1, s0, t, p} <= '0;
                    end else if (accept) begin
                        case (idx)
                            IDX_S2:  s2 <= vote_in;
                            IDX_S1:  s1 <= vote_in;
                            IDX_S0:  s0 <= vote_in;
                            IDX_T:   t  <= vote_in;
                            IDX_P:   p  <= vote_in;
                            default: ;
                        endcase
                        idx   <= idx + 3'd1;
                        timer <= '0;
                    end else if (tmo) begin
                        {s2, s1, s0, t, p} <= '0;
                        timeout_err        <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                EVAL: begin
                    if (abort) begin
                        {s2, s1, s0, t, p} <= '0;
                    end else begin
                        result <= g;
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_pass (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pass_inc),
        .count (pass_count)
    );

    sat_counter #(.W(CNT_W)) u_fail (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fail_inc),
        .count (fail_count)
    );

endmodule

// File: tb/tb_ballot_collector.sv
// Directed table-driven bench for ballot_collector.
// Voting stage modelled inline; g = maj(maj(s2,s1,s0), t, p).
module tb_ballot_collector;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       vote_valid;
    logic       vote_in;
    logic       vote_ready;
    logic       g;
    logic       s2, s1, s0, t, p;
    logic       busy;
    logic       ballot_done;
    logic       result;
    logic [1:0] pass_count;
    logic [1:0] fail_count;
    logic       timeout_err;

    ballot_collector #(
        .TIMEOUT (4),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .vote_valid  (vote_valid),
        .vote_in     (vote_in),
        .vote_ready  (vote_ready),
        .g           (g),
        .s2          (s2),
        .s1          (s1),
        .s0          (s0),
        .t           (t),
        .p           (p),
        .busy        (busy),
        .ballot_done (ballot_done),
        .result      (result),
        .pass_count  (pass_count),
        .fail_count  (fail_count),
        .timeout_err (timeout_err)
    );

    logic smaj;
    assign smaj = (s2 & s1) | (s2 & s0) | (s1 & s0);
    assign g    = (smaj & t) | (smaj & p) | (t & p);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs: {start, abort, vote_valid, vote_in}
    // outputs: {ready, busy, done, result, s2..p, pass, fail, terr}
    typedef struct {
        logic [3:0]  in;
        logic [13:0] exp;
    } vec_t;

    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] ST  = 4'b1000;
    localparam logic [3:0] AB  = 4'b0100;
    localparam logic [3:0] V0  = 4'b0010;
    localparam logic [3:0] V1  = 4'b0011;

    vec_t tbl[$];
    int   n_vec;
    int   n_err;

    function automatic logic [13:0] outs();
        return {vote_ready, busy, ballot_done, result,
                s2, s1, s0, t, p,
                pass_count, fail_count, timeout_err};
    endfunction

    task automatic row(input logic [3:0] in, input logic [3:0] ctl,
                       input logic [4:0] vt, input logic [1:0] pc,
                       input logic [1:0] fc, input logic te);
        vec_t v;
        v.in  = in;
        v.exp = {ctl, vt, pc, fc, te};
        tbl.push_back(v);
    endtask

    task automatic gap(input int n, input logic [3:0] ctl,
                       input logic [4:0] vt, input logic [1:0] pc,
                       input logic [1:0] fc);
        for (int k = 0; k < n; k++) row(NOP, ctl, vt, pc, fc, 1'b0);
    endtask

    // all-yes ballot, previous result already 1
    task automatic pass_ballot(input logic [1:0] pc0,
                               input logic [1:0] pc1,
                               input logic [1:0] fc);
        row(ST, 4'b1101, 5'b00000, pc0, fc, 1'b0);
        row(V1, 4'b1101, 5'b10000, pc0, fc, 1'b0);
        row(V1, 4'b1101, 5'b11000, pc0, fc, 1'b0);
        row(V1, 4'b1101, 5'b11100, pc0, fc, 1'b0);
        row(V1, 4'b1101, 5'b11110, pc0, fc, 1'b0);
        row(V1, 4'b0101, 5'b11111, pc0, fc, 1'b0);
        row(NOP, 4'b0111, 5'b11111, pc1, fc, 1'b0);
        row(NOP, 4'b0001, 5'b11111, pc1, fc, 1'b0);
    endtask

    task automatic chk(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] in);
        {start, abort, vote_valid, vote_in} = in;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(NOP);

        // ballot 1: 1,1,0,1,0 back-to-back -> pass
        row(ST,  4'b1100, 5'b00000, 2'd0, 2'd0, 1'b0);
        row(V1,  4'b1100, 5'b10000, 2'd0, 2'd0, 1'b0);
        row(V1,  4'b1100, 5'b11000, 2'd0, 2'd0, 1'b0);
        row(V0,  4'b1100, 5'b11000, 2'd0, 2'd0, 1'b0);
        row(V1,  4'b1100, 5'b11010, 2'd0, 2'd0, 1'b0);
        row(V0,  4'b0100, 5'b11010, 2'd0, 2'd0, 1'b0);
        row(NOP, 4'b0111, 5'b11010, 2'd1, 2'd0, 1'b0);
        row(NOP, 4'b0001, 5'b11010, 2'd1, 2'd0, 1'b0);

        // ballot 2: 1,1,1,0,0 with 3-cycle gaps -> fail
        row(ST,  4'b1101, 5'b00000, 2'd1, 2'd0, 1'b0);
        row(V1,  4'b1101, 5'b10000, 2'd1, 2'd0, 1'b0);
        gap(3,   4'b1101, 5'b10000, 2'd1, 2'd0);
        row(V1,  4'b1101, 5'b11000, 2'd1, 2'd0, 1'b0);
        gap(3,   4'b1101, 5'b11000, 2'd1, 2'd0);
        row(V1,  4'b1101, 5'b11100, 2'd1, 2'd0, 1'b0);
        gap(3,   4'b1101, 5'b11100, 2'd1, 2'd0);
        row(V0,  4'b1101, 5'b11100, 2'd1, 2'd0, 1'b0);
        gap(3,   4'b1101, 5'b11100, 2'd1, 2'd0);
        row(V0,  4'b0101, 5'b11100, 2'd1, 2'd0, 1'b0);
        row(NOP, 4'b0110, 5'b11100, 2'd1, 2'd1, 1'b0);
        gap(2,   4'b0000, 5'b11100, 2'd1, 2'd1);

        // abort together with vote_valid after 3 votes
        row(ST,  4'b1100, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b10000, 2'd1, 2'd1, 1'b0);
        row(V0,  4'b1100, 5'b10000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b10100, 2'd1, 2'd1, 1'b0);
        row(AB | V1, 4'b0000, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(NOP, 4'b0000, 5'b00000, 2'd1, 2'd1, 1'b0);

        // timeout after 4 silent cycles
        row(ST,  4'b1100, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b10000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b11000, 2'd1, 2'd1, 1'b0);
        gap(3,   4'b1100, 5'b11000, 2'd1, 2'd1);
        row(NOP, 4'b0000, 5'b00000, 2'd1, 2'd1, 1'b1);
        row(NOP, 4'b0000, 5'b00000, 2'd1, 2'd1, 1'b1);
        row(ST,  4'b1100, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(AB,  4'b0000, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(ST | AB, 4'b1100, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(AB,  4'b0000, 5'b00000, 2'd1, 2'd1, 1'b0);

        // start while busy is ignored; index keeps its place
        row(ST,  4'b1100, 5'b00000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b10000, 2'd1, 2'd1, 1'b0);
        row(ST,  4'b1100, 5'b10000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b11000, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b11100, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b1100, 5'b11110, 2'd1, 2'd1, 1'b0);
        row(V1,  4'b0100, 5'b11111, 2'd1, 2'd1, 1'b0);
        row(ST,  4'b0111, 5'b11111, 2'd2, 2'd1, 1'b0);
        row(ST,  4'b0001, 5'b11111, 2'd2, 2'd1, 1'b0);

        // saturation of the 2-bit pass tally
        pass_ballot(2'd2, 2'd3, 2'd1);
        pass_ballot(2'd3, 2'd3, 2'd1);

        step();
        step();
        chk("reset_low", outs(), 14'd0);
        rst_n = 1'b1;
        step();
        chk("reset_rel", outs(), 14'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in);
            step();
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        drive(NOP);

        // async reset while in EVAL
        drive(ST);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(V1);
            step();
        end
        drive(NOP);
        chk("pre_rst_eval", outs(),
            {4'b0101, 5'b11111, 2'd3, 2'd1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", outs(), 14'd0);
        step();
        chk("rst_held", outs(), 14'd0);
        rst_n = 1'b1;
        drive(ST);
        step();
        drive(NOP);
        chk("post_rst_start", outs(),
            {4'b1100, 5'b00000, 2'd0, 2'd0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
